// File: rtl/array_multiplier.sv
// Signed Baugh-Wooley array multiplier: carry-save partial-product array,
// ripple-carry final adder and one output register stage (1-cycle latency).
module array_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0][PW-1:0] pp_row;
  logic [PW-1:0]            bw_const;
  logic [PW-1:0]            product_d;

  // Sign compensation for the inverted MSB partial products.
  always_comb begin
    bw_const            = '0;
    bw_const[WIDTH]     = 1'b1;
    bw_const[PW-1]      = 1'b1;
  end

  // Row i holds A & B[i], already shifted left by i; terms pairing exactly one
  // operand MSB are complemented.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    for (genvar k = 0; k < PW; k++) begin : g_bit
      if (k >= i && k < i + WIDTH) begin : g_term
        localparam int J = k - i;
        if ((i == WIDTH - 1) != (J == WIDTH - 1)) begin : g_inv
          assign pp_row[i][k] = ~(A[J] & B[i]);
        end else begin : g_pos
          assign pp_row[i][k] = A[J] & B[i];
        end
      end else begin : g_pad
        assign pp_row[i][k] = 1'b0;
      end
    end
  end

  // Carry-save reduction: each row folds one more partial product into the
  // running sum/carry pair. Carries past bit PW-1 fall off (result is mod 2^PW).
  for (genvar r = 0; r < WIDTH; r++) begin : g_csa
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    if (r == 0) begin : g_seed
      assign s = pp_row[0];
      assign c = bw_const;
    end else begin : g_fa
      assign c[0] = 1'b0;
      for (genvar k = 0; k < PW; k++) begin : g_bit
        assign s[k] = g_csa[r-1].s[k] ^ g_csa[r-1].c[k] ^ pp_row[r][k];
        if (k < PW - 1) begin : g_cout
          assign c[k+1] = (g_csa[r-1].s[k] & g_csa[r-1].c[k])
                        | (pp_row[r][k] & (g_csa[r-1].s[k] ^ g_csa[r-1].c[k]));
        end
      end
    end
  end

  // Final ripple-carry row merging the last sum and carry vectors.
  always_comb begin
    logic carry;
    logic sb;
    logic cb;
    carry     = 1'b0;
    product_d = '0;
    for (int k = 0; k < PW; k++) begin
      sb           = g_csa[WIDTH-1].s[k];
      cb           = g_csa[WIDTH-1].c[k];
      product_d[k] = sb ^ cb ^ carry;
      carry        = (sb & cb) | (carry & (sb ^ cb));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the combinational blocks above use blocking order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      product   <= product_d;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_array_multiplier.sv
// Self-checking bench for array_multiplier at WIDTH = 8, 32 and 64: directed
// vectors, reset corner cases and randomized pairs against a plain-arithmetic model.
module tb_array_multiplier;

  logic clk;
  logic rst;
  logic in_valid;
  logic signed [7:0]  a8,  b8;
  logic signed [31:0] a32, b32;
  logic signed [63:0] a64, b64;
  logic [15:0]  p8;
  logic [63:0]  p32;
  logic [127:0] p64;
  logic ov8, ov32, ov64;

  int n_checks = 0;
  int n_fail   = 0;

  array_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a8), .B(b8),
    .out_valid(ov8), .product(p8)
  );
  array_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a32), .B(b32),
    .out_valid(ov32), .product(p32)
  );
  array_multiplier #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a64), .B(b64),
    .out_valid(ov64), .product(p64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [63:0] p;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact signed product in 128-bit arithmetic.
  function automatic logic [127:0] smul(input logic signed [63:0] a, input logic signed [63:0] b);
    logic signed [127:0] ea;
    logic signed [127:0] eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  initial begin
    logic [127:0] r8, r32, r64;
    logic         iv;

    vecs[0] = '{a: 32'sd0,          b: 32'sd0,          p: 64'sd0};
    vecs[1] = '{a: 32'sd1,          b: 32'sd0,          p: 64'sd0};
    vecs[2] = '{a: 32'sd0,          b: -32'sd1,         p: 64'sd0};
    vecs[3] = '{a: -32'sd2,         b: 32'sd0,          p: 64'sd0};
    vecs[4] = '{a: 32'sd2,          b: -32'sd2,         p: -64'sd4};
    vecs[5] = '{a: -32'sd2,         b: 32'sd2,          p: -64'sd4};
    vecs[6] = '{a: -32'sd2,         b: -32'sd2,         p: 64'sd4};
    vecs[7] = '{a: 32'h7FFF_FFFF,   b: 32'h8000_0000,   p: -64'sd4611686016279904256};
    vecs[8] = '{a: 32'h8000_0000,   b: 32'h8000_0000,   p: 64'sd4611686018427387904};
    vecs[9] = '{a: 32'h7FFF_FFFF,   b: 32'h7FFF_FFFF,   p: 64'sd4611686014132420609};

    rst = 1'b1; in_valid = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;

    // Reset state, held across a clock edge
    step();
    check("reset_p8",   {112'd0, p8},  128'd0);
    check("reset_p32",  {64'd0, p32},  128'd0);
    check("reset_p64",  p64,           128'd0);
    check("reset_ov",   {125'd0, ov8, ov32, ov64}, 128'd0);

    // First capture after release
    rst = 1'b0; a32 = 32'sd5; b32 = 32'sd3; in_valid = 1'b1;
    step();
    check("first_p32",  {64'd0, p32}, 128'd15);
    check("first_ov32", {127'd0, ov32}, 128'd1);

    // Asynchronous reset mid-cycle clears before the next edge
    #2 rst = 1'b1;
    #1;
    check("async_p32",  {64'd0, p32}, 128'd0);
    check("async_ov32", {127'd0, ov32}, 128'd0);
    step();
    check("held_p32",   {64'd0, p32}, 128'd0);
    check("held_ov32",  {127'd0, ov32}, 128'd0);

    // Directed vectors; the first is presented in the cycle reset releases.
    // The last three run back-to-back as the extreme-pair sequence.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a32 = vecs[i].a; b32 = vecs[i].b; in_valid = 1'b1;
      step();
      check($sformatf("vec%0d_p32", i), {64'd0, p32}, {64'd0, vecs[i].p[63:0]});
      check($sformatf("vec%0d_ov32", i), {127'd0, ov32}, 128'd1);
    end

    // Product keeps updating with in_valid low; out_valid drops
    a32 = 32'sd7; b32 = -32'sd3; in_valid = 1'b0;
    step();
    check("idle_ov32", {127'd0, ov32}, 128'd0);
    check("idle_p32",  {64'd0, p32},  {64'd0, 64'hFFFF_FFFF_FFFF_FFEB});

    // Randomized pairs on all three widths; first two force the extremes
    for (int n = 0; n < 64; n++) begin
      if (n == 0) begin
        a8 = 8'h80; b8 = 8'h80; a32 = 32'h8000_0000; b32 = 32'h8000_0000;
        a64 = 64'h8000_0000_0000_0000; b64 = 64'h8000_0000_0000_0000;
      end else if (n == 1) begin
        a8 = 8'h7F; b8 = 8'h80; a32 = 32'h7FFF_FFFF; b32 = 32'h8000_0000;
        a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h8000_0000_0000_0000;
      end else begin
        a8  = 8'($urandom);  b8  = 8'($urandom);
        a32 = $urandom;      b32 = $urandom;
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
      end
      iv = 1'($urandom_range(0, 1));
      in_valid = iv;
      r8  = smul(a8,  b8);
      r32 = smul(a32, b32);
      r64 = smul(a64, b64);
      step();
      check($sformatf("rnd%0d_p8", n),  {112'd0, p8},  {112'd0, r8[15:0]});
      check($sformatf("rnd%0d_p32", n), {64'd0, p32},  {64'd0, r32[63:0]});
      check($sformatf("rnd%0d_p64", n), p64,           r64);
      check($sformatf("rnd%0d_ov", n),  {125'd0, ov8, ov32, ov64}, {125'd0, iv, iv, iv});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/array_multiplier.md
Name: array_multiplier

Overview:
- Signed two's-complement array multiplier with a registered output.
- Computes the exact 2*WIDTH-bit product of two WIDTH-bit signed operands using a combinational Baugh-Wooley partial-product array, followed by one output register stage.
- Used as a drop-in arithmetic leaf in datapaths that need deterministic 1-cycle multiply latency.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  A/B valid this cycle
- A  input  WIDTH  signed multiplicand, two's complement
- B  input  WIDTH  signed multiplier, two's complement
- out_valid  output  1  product holds the result of a valid operand pair
- product  output  2*WIDTH  signed product A*B, two's complement

Behaviour:
- Reset:
  - rst high immediately, without waiting for clk, forces product=0 and out_valid=0.
  - Both outputs hold those values while rst is high.
  - The first capture after reset deasserts happens on the next rising clk edge.
- Datapath structure:
  - WIDTH x WIDTH AND-gate partial-product matrix.
  - Baugh-Wooley sign handling: invert partial products that involve exactly one MSB. Add constant 1 at bit position WIDTH and at bit position 2*WIDTH-1.
  - Rows reduced by a carry-save array of full/half adders built with generate loops.
  - Final ripple-carry adder row.
  - The HDL '*' operator must not appear in the datapath.
- Arithmetic:
  - Result is exact: no truncation, no saturation, no overflow for any input pair.
  - Corner case: (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = 2^(2*WIDTH-2), which is representable and positive.
- Timing and handshake:
  - On each rising clk edge with rst low: product <= A*B, out_valid <= in_valid.
  - Latency is exactly 1 cycle. Throughput is one operation per cycle.
  - product updates every cycle regardless of in_valid. Consumers must qualify it with out_valid.
- Back-to-back operands: each edge captures the current A/B. There is no stall and no backpressure.
- Reset mid-operation: an in-flight result is discarded (product=0, out_valid=0). An operand presented during the cycle reset releases is captured normally at the next edge.
- X handling: none required; inputs are assumed driven.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with product nonzero -> product=0 and out_valid=0 before the next clk edge. Release rst, apply A=5, B=3, in_valid=1 -> one edge later product=15, out_valid=1.
- Zero and sign operands:
  - A=0, B=0 -> 0
  - A=1, B=0 -> 0
  - A=0, B=-1 -> 0
  - A=-2, B=0 -> 0
  - A=2, B=-2 -> -4
  - A=-2, B=2 -> -4
  - A=-2, B=-2 -> 4
- WIDTH=32 extremes:
  - A=2147483647, B=-2147483648 -> -4611686016279904256
  - A=-2147483648, B=-2147483648 -> 4611686018427387904
  - A=2147483647, B=2147483647 -> 4611686014132420609
- Back-to-back: apply the three extreme pairs on consecutive cycles with in_valid=1, then in_valid=0 -> results appear in order on consecutive cycles, then out_valid=0.
- Random: 50+ random signed pairs at WIDTH=32, and again at WIDTH=8 and WIDTH=64 -> product matches the 2*WIDTH-bit signed reference product one cycle later. Zero mismatches.
